rx_frame_parser: RTL and testbench

// Receive-side counterpart of the pattern-generator TX controller. Consumes the MAC rx AXI-Stream

---
 rtl/rx_frame_parser_pkg.sv | 24 ++
 rtl/rx_header_capture.sv | 49 ++++
 rtl/rx_frame_parser.sv | 173 +++++++++++++++++
 tb/tb_rx_frame_parser.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_parser_pkg.sv
// Shared types and constants for the receive-side Ethernet frame parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_frame_parser_pkg;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int ETH_MAX_PAYLOAD = 1500;

  // Ethernet header as it appears on the wire, first byte in the MSBs.
  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] len_type;
  } eth_hdr_t;

  // Receive parser state; kept separate from the TX controller's state type.
  typedef enum logic [1:0] {
    IDLE,
    HEADER_BYTES,
    DATA_BYTES,
    DROP
  } rx_fsm_t;

endpackage

// File: rtl/rx_header_capture.sv
// Shifts header bytes in MSB-first and flags the byte that completes the header.
// Latency: hdr_next/done are combinational on the current byte; the shift register updates 1 clk later.
// Backpressure: none; every enabled byte is taken.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          a header byte is present this cycle
//   start       the present byte is byte 0 of a frame (restarts the byte count)
//   din         present byte
//   hdr_next    shift register contents including the present byte
//   done        the present byte is the last header byte
module rx_header_capture #(
  parameter int HDR_BYTES = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   start,
  input  logic [7:0]             din,
  output logic [HDR_BYTES*8-1:0] hdr_next,
  output logic                   done
);

  localparam int HDR_W = HDR_BYTES * 8;
  localparam int CNT_W = $clog2(HDR_BYTES + 1);

  logic [HDR_W-1:0] hdr_shift;
  logic [CNT_W-1:0] hdr_cnt;

  assign hdr_next = {hdr_shift[HDR_W-9:0], din};

  // hdr_cnt may be stale from a runt frame, so byte 0 never counts as completing.
  assign done = en && !start && (hdr_cnt == CNT_W'(HDR_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_shift <= '0;
      hdr_cnt   <= '0;
    end else if (en) begin
      hdr_shift <= hdr_next;
      if (start) begin
        hdr_cnt <= CNT_W'(1);
      end else if (hdr_cnt != CNT_W'(HDR_BYTES)) begin
        hdr_cnt <= hdr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rx_frame_parser.sv
// Strips the Ethernet header from the MAC rx byte stream and writes the payload into brx, committing or rewinding each frame.
// Latency: 1 clk from the accepting tvalid edge to brx_wr_en and every pulse output.
// Backpressure: none upstream (no tready); brx_full on a payload byte drops the rest of the frame.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rx_axis_tdata/tvalid/tlast/tuser MAC receive stream; tuser marks a bad frame on the tlast byte
//   brx_full                         receive buffer cannot take a write this cycle
//   brx_wr_en, brx_wr_data           payload byte write into brx
//   brx_commit, brx_rewind           publish / discard bytes written since the last commit or rewind
//   rx_header_valid, rx_header       header fields updated (held until the next header completes)
//   payload_len                      payload byte count, valid with brx_commit
//   frame_err                        frame dropped (tuser, runt, oversize, overflow)
module rx_frame_parser
  import rx_frame_parser_pkg::*;
#(
  parameter int SIZE        = 2048,
  parameter int HDR_BYTES   = ETH_HDR_BYTES,
  parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_axis_tdata,
  input  logic                     rx_axis_tvalid,
  input  logic                     rx_axis_tlast,
  input  logic                     rx_axis_tuser,
  input  logic                     brx_full,
  output logic                     brx_wr_en,
  output logic [7:0]               brx_wr_data,
  output logic                     brx_commit,
  output logic                     brx_rewind,
  output logic                     rx_header_valid,
  output eth_hdr_t                 rx_header,
  output logic [$clog2(SIZE+1)-1:0] payload_len,
  output logic                     frame_err
);

  localparam int LEN_W = $clog2(SIZE + 1);

  rx_fsm_t                state, state_nxt;
  logic [LEN_W-1:0]       pay_cnt, pay_cnt_nxt, len_nxt;
  logic                   wr_en_nxt, commit_nxt, rewind_nxt, hv_nxt, err_nxt;
  logic                   hdr_en, hdr_start, hdr_done;
  logic [HDR_BYTES*8-1:0] hdr_next;
  logic                   over;

  assign hdr_start = (state == IDLE);
  assign hdr_en    = rx_axis_tvalid && ((state == IDLE) || (state == HEADER_BYTES));

  // A payload byte that cannot be written: buffer full, or it would exceed the payload limit.
  assign over = brx_full || (pay_cnt == LEN_W'(MAX_PAYLOAD));

  rx_header_capture #(
    .HDR_BYTES (HDR_BYTES)
  ) u_hdr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (hdr_en),
    .start    (hdr_start),
    .din      (rx_axis_tdata),
    .hdr_next (hdr_next),
    .done     (hdr_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (rx_axis_tvalid) begin
      case (state)
        IDLE:         if (!rx_axis_tlast) state_nxt = HEADER_BYTES;
        HEADER_BYTES: begin
          if (rx_axis_tlast)  state_nxt = IDLE;
          else if (hdr_done)  state_nxt = DATA_BYTES;
        end
        DATA_BYTES: begin
          if (rx_axis_tlast)  state_nxt = IDLE;
          else if (over)      state_nxt = DROP;
        end
        DROP:         if (rx_axis_tlast) state_nxt = IDLE;
        default:      state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs and the payload counter
  always_comb begin
    wr_en_nxt   = 1'b0;
    commit_nxt  = 1'b0;
    rewind_nxt  = 1'b0;
    hv_nxt      = 1'b0;
    err_nxt     = 1'b0;
    len_nxt     = '0;
    pay_cnt_nxt = pay_cnt;
    if (rx_axis_tvalid) begin
      case (state)
        IDLE: begin
          if (rx_axis_tlast) err_nxt = 1'b1;
        end
        HEADER_BYTES: begin
          if (hdr_done) begin
            hv_nxt      = 1'b1;
            pay_cnt_nxt = '0;
            // Header-only frame: nothing was written, so a bad one needs no rewind.
            if (rx_axis_tlast) begin
              if (rx_axis_tuser) err_nxt    = 1'b1;
              else               commit_nxt = 1'b1;
            end
          end else if (rx_axis_tlast) begin
            err_nxt = 1'b1;
          end
        end
        DATA_BYTES: begin
          if (over || (rx_axis_tlast && rx_axis_tuser)) begin
            if (rx_axis_tlast) begin
              rewind_nxt = 1'b1;
              err_nxt    = 1'b1;
            end
          end else begin
            wr_en_nxt   = 1'b1;
            pay_cnt_nxt = pay_cnt + LEN_W'(1);
            if (rx_axis_tlast) begin
              commit_nxt = 1'b1;
              len_nxt    = pay_cnt + LEN_W'(1);
            end
          end
        end
        DROP: begin
          // pay_cnt is left alone here, so it saturates at the drop point.
          if (rx_axis_tlast) begin
            rewind_nxt = 1'b1;
            err_nxt    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brx_wr_en       <= 1'b0;
      brx_wr_data     <= '0;
      brx_commit      <= 1'b0;
      brx_rewind      <= 1'b0;
      rx_header_valid <= 1'b0;
      rx_header       <= '0;
      payload_len     <= '0;
      frame_err       <= 1'b0;
      pay_cnt         <= '0;
    end else begin
      brx_wr_en       <= wr_en_nxt;
      brx_commit      <= commit_nxt;
      brx_rewind      <= rewind_nxt;
      rx_header_valid <= hv_nxt;
      frame_err       <= err_nxt;
      pay_cnt         <= pay_cnt_nxt;
      if (wr_en_nxt)  brx_wr_data <= rx_axis_tdata;
      if (hv_nxt)     rx_header   <= eth_hdr_t'(hdr_next);
      if (commit_nxt) payload_len <= len_nxt;
    end
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: one task per scenario, inline comparisons.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_frame_parser;
  import rx_frame_parser_pkg::*;

  localparam int SIZE  = 2048;
  localparam int LEN_W = $clog2(SIZE + 1);
  localparam logic [111:0] H_A = {48'hFFFFFFFFFFFF, 48'h000A35010203, 16'h0800};
  localparam logic [111:0] H_B = {48'h112233445566, 48'h000A35AABBCC, 16'h88B5};

  logic             clk;
  logic             rst_n;
  logic [7:0]       rx_axis_tdata;
  logic             rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser, brx_full;
  logic             brx_wr_en, brx_commit, brx_rewind, rx_header_valid, frame_err;
  logic [7:0]       brx_wr_data;
  eth_hdr_t         rx_header;
  logic [LEN_W-1:0] payload_len;

  rx_frame_parser #(.SIZE(SIZE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_axis_tdata   (rx_axis_tdata),
    .rx_axis_tvalid  (rx_axis_tvalid),
    .rx_axis_tlast   (rx_axis_tlast),
    .rx_axis_tuser   (rx_axis_tuser),
    .brx_full        (brx_full),
    .brx_wr_en       (brx_wr_en),
    .brx_wr_data     (brx_wr_data),
    .brx_commit      (brx_commit),
    .brx_rewind      (brx_rewind),
    .rx_header_valid (rx_header_valid),
    .rx_header       (rx_header),
    .payload_len     (payload_len),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event monitor, sampled on the falling edge.
  int         hv_cnt, commit_cnt, rewind_cnt, err_cnt;
  int         excl_bad = 0;
  logic [7:0] wr_log[$];
  int         len_log[$];
  logic [7:0] fb [0:1599];

  always @(negedge clk) begin
    if (rst_n) begin
      if (brx_wr_en)       wr_log.push_back(brx_wr_data);
      if (rx_header_valid) hv_cnt++;
      if (brx_commit) begin
        commit_cnt++;
        len_log.push_back(int'(payload_len));
      end
      if (brx_rewind) rewind_cnt++;
      if (frame_err)  err_cnt++;
      if (brx_commit && (brx_rewind || frame_err)) excl_bad++;
    end
  end

  task automatic clear_mon();
    hv_cnt = 0; commit_cnt = 0; rewind_cnt = 0; err_cnt = 0;
    wr_log.delete();
    len_log.delete();
  endtask

  task automatic build_frame(input logic [111:0] h, input int npay);
    for (int i = 0; i < 14; i++) fb[i] = h[111-8*i -: 8];
    for (int j = 0; j < npay; j++) fb[14+j] = j[7:0];
  endtask

  // Drives the first cnt bytes of a len-byte frame; tlast/tuser on byte len-1, brx_full on byte full_idx.
  task automatic drive_frame(input int len, input int cnt, input bit tu, input int full_idx);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      rx_axis_tvalid = 1'b1;
      rx_axis_tdata  = fb[i];
      rx_axis_tlast  = (i == len - 1);
      rx_axis_tuser  = (i == len - 1) ? tu : 1'b0;
      brx_full       = (i == full_idx);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0; brx_full = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Counts payload bytes in wr_log[from..from+n-1] that differ from the ramp 0,1,2,...
  function automatic int ramp_bad(input int from, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (from + i >= wr_log.size() || wr_log[from+i] !== i[7:0]) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0;
    rx_axis_tdata = 8'h00; brx_full = 1'b0;
    clear_mon();
    repeat (2) @(negedge clk);
    checks++;
    if ({brx_wr_en, brx_commit, brx_rewind, rx_header_valid, frame_err, brx_wr_data, payload_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr_en=%b commit=%b rewind=%b hv=%b err=%b data=%h len=%0d, required all 0",
               brx_wr_en, brx_commit, brx_rewind, rx_header_valid, frame_err, brx_wr_data, payload_len);
    end
    checks++;
    if (rx_header !== 112'h0) begin
      errors++; $display("FAIL reset_header: got %h required 0", rx_header);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_64();
    clear_mon();
    build_frame(H_A, 50);
    drive_frame(64, 64, 1'b0, -1);
    go_idle();
    checks++;
    if (hv_cnt != 1 || commit_cnt != 1 || rewind_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL basic64_events: got hv=%0d commit=%0d rewind=%0d err=%0d, required 1 1 0 0",
               hv_cnt, commit_cnt, rewind_cnt, err_cnt);
    end
    checks++;
    if (wr_log.size() != 50 || ramp_bad(0, 50) != 0) begin
      errors++; $display("FAIL basic64_writes: got %0d writes (%0d wrong), required 50 bytes 0..49",
                         wr_log.size(), ramp_bad(0, 50));
    end
    checks++;
    if (len_log.size() != 1 || len_log[0] != 50) begin
      errors++; $display("FAIL basic64_len: got %0d commits, first len %0d, required len 50",
                         len_log.size(), (len_log.size() > 0) ? len_log[0] : -1);
    end
    checks++;
    if (rx_header !== H_A) begin
      errors++; $display("FAIL basic64_header: got %h required %h", rx_header, H_A);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    build_frame(H_A, 50);
    drive_frame(64, 64, 1'b0, -1);
    build_frame(H_B, 16);
    drive_frame(30, 30, 1'b0, -1);
    go_idle();
    checks++;
    if (hv_cnt != 2 || commit_cnt != 2 || err_cnt != 0 || wr_log.size() != 66) begin
      errors++;
      $display("FAIL b2b_events: got hv=%0d commit=%0d err=%0d writes=%0d, required 2 2 0 66",
               hv_cnt, commit_cnt, err_cnt, wr_log.size());
    end
    checks++;
    if (len_log.size() != 2 || len_log[0] != 50 || len_log[1] != 16) begin
      errors++; $display("FAIL b2b_lens: got %0d commits, lens %0d/%0d, required 50/16", len_log.size(),
                         (len_log.size() > 0) ? len_log[0] : -1, (len_log.size() > 1) ? len_log[1] : -1);
    end
    checks++;
    if (ramp_bad(0, 50) != 0 || ramp_bad(50, 16) != 0 || rx_header !== H_B) begin
      errors++; $display("FAIL b2b_data: wrong bytes %0d/%0d, header %h required %h",
                         ramp_bad(0, 50), ramp_bad(50, 16), rx_header, H_B);
    end
  endtask

  task automatic test_runt();
    clear_mon();
    build_frame(H_B, 0);
    drive_frame(10, 10, 1'b0, -1);
    go_idle();
    checks++;
    if (err_cnt != 1 || hv_cnt != 0 || wr_log.size() != 0 || rewind_cnt != 0 || commit_cnt != 0) begin
      errors++;
      $display("FAIL runt_events: got err=%0d hv=%0d writes=%0d rewind=%0d commit=%0d, required 1 0 0 0 0",
               err_cnt, hv_cnt, wr_log.size(), rewind_cnt, commit_cnt);
    end
    checks++;
    if (rx_header !== H_B) begin
      errors++; $display("FAIL runt_header_held: got %h required %h", rx_header, H_B);
    end
  endtask

  task automatic test_tuser();
    clear_mon();
    build_frame(H_A, 46);
    drive_frame(60, 60, 1'b1, -1);
    go_idle();
    checks++;
    if (wr_log.size() != 45 || rewind_cnt != 1 || err_cnt != 1 || commit_cnt != 0 || hv_cnt != 1) begin
      errors++;
      $display("FAIL tuser_events: got writes=%0d rewind=%0d err=%0d commit=%0d hv=%0d, required 45 1 1 0 1",
               wr_log.size(), rewind_cnt, err_cnt, commit_cnt, hv_cnt);
    end
  endtask

  task automatic test_brx_full();
    clear_mon();
    build_frame(H_A, 86);
    drive_frame(100, 100, 1'b0, 33);
    go_idle();
    checks++;
    if (wr_log.size() != 19 || ramp_bad(0, 19) != 0 || rewind_cnt != 1 || err_cnt != 1 || commit_cnt != 0) begin
      errors++;
      $display("FAIL full_drop: got writes=%0d rewind=%0d err=%0d commit=%0d, required 19 1 1 0",
               wr_log.size(), rewind_cnt, err_cnt, commit_cnt);
    end
    clear_mon();
    build_frame(H_B, 50);
    drive_frame(64, 64, 1'b0, -1);
    go_idle();
    checks++;
    if (commit_cnt != 1 || len_log.size() != 1 || len_log[0] != 50 || wr_log.size() != 50 || err_cnt != 0) begin
      errors++;
      $display("FAIL full_recover: got commit=%0d writes=%0d err=%0d, required 1 commit len 50, 50 writes, 0 err",
               commit_cnt, wr_log.size(), err_cnt);
    end
  endtask

  task automatic test_oversize();
    clear_mon();
    build_frame(H_A, 1515);
    drive_frame(1529, 1529, 1'b0, -1);
    go_idle();
    checks++;
    if (wr_log.size() != 1500 || ramp_bad(0, 1500) != 0) begin
      errors++; $display("FAIL oversize_writes: got %0d writes (%0d wrong), required 1500",
                         wr_log.size(), ramp_bad(0, 1500));
    end
    checks++;
    if (rewind_cnt != 1 || err_cnt != 1 || commit_cnt != 0 || hv_cnt != 1) begin
      errors++;
      $display("FAIL oversize_events: got rewind=%0d err=%0d commit=%0d hv=%0d, required 1 1 0 1",
               rewind_cnt, err_cnt, commit_cnt, hv_cnt);
    end
  endtask

  task automatic test_async_reset();
    clear_mon();
    build_frame(H_A, 50);
    drive_frame(64, 30, 1'b0, -1);
    @(posedge clk);
    #2;
    checks++;
    if (brx_wr_en !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got wr_en=%b required 1", brx_wr_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({brx_wr_en, brx_commit, brx_rewind, rx_header_valid, frame_err, brx_wr_data, payload_len} !== '0
        || rx_header !== 112'h0) begin
      errors++;
      $display("FAIL areset_outputs: got wr_en=%b data=%h header=%h, required all 0",
               brx_wr_en, brx_wr_data, rx_header);
    end
    rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_header_only();
    clear_mon();
    build_frame(H_B, 0);
    drive_frame(14, 14, 1'b0, -1);
    go_idle();
    checks++;
    if (commit_cnt != 1 || len_log.size() != 1 || len_log[0] != 0 || hv_cnt != 1 || wr_log.size() != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL hdr14: got commit=%0d hv=%0d writes=%0d err=%0d, required 1 commit len 0, hv 1, 0 writes, 0 err",
               commit_cnt, hv_cnt, wr_log.size(), err_cnt);
    end
    checks++;
    if (rx_header !== H_B) begin
      errors++; $display("FAIL hdr14_header: got %h required %h", rx_header, H_B);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (excl_bad != 0) begin
      errors++; $display("FAIL pulse_exclusive: got %0d overlapping cycles, required 0", excl_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_64();
    test_back_to_back();
    test_runt();
    test_tuser();
    test_brx_full();
    test_oversize();
    test_async_reset();
    test_header_only();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
